// File: rtl/wb_stream_reader_pkg.sv
// Shared constants for the stream-to-memory DMA: register word offsets,
// Wishbone cycle-type codes and master FSM state encoding.
package wb_stream_reader_pkg;

  // Register select values, taken from slave address bits [4:2]
  localparam logic [2:0] REG_CSR        = 3'd0;
  localparam logic [2:0] REG_START_ADDR = 3'd1;
  localparam logic [2:0] REG_BUF_SIZE   = 3'd2;
  localparam logic [2:0] REG_BURST_SIZE = 3'd3;
  localparam logic [2:0] REG_TX_CNT     = 3'd4;

  // Wishbone cycle type identifiers
  localparam logic [2:0] CTI_INC = 3'b010;
  localparam logic [2:0] CTI_EOB = 3'b111;

  // Master FSM states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/wb_stream_reader_fifo.sv
// First-word-fall-through FIFO: rd_data always shows the head word, and
// count reports occupancy so the master can wait for a whole burst.
module stream_fifo #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          full,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem [2**AW];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          push;
  logic          pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == DEPTH);
  assign empty   = (count == '0);
  assign push    = wr_en & ~full;
  assign pop     = rd_en & ~empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Storage array needs no reset; only words behind the pointers are visible
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Pointer update; a simultaneous push and pop leaves the count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/wb_stream_reader.sv
// Stream-to-memory DMA. Buffers an incoming valid/ready word stream and
// writes it to memory as Wishbone incrementing bursts; a Wishbone slave
// port holds the configuration and status registers.
module wb_stream_reader
  import wb_stream_reader_pkg::*;
#(
  parameter int FIFO_AW       = 5,
  parameter int MAX_BURST_LEN = 32,
  parameter int WB_AW         = 32,
  parameter int WB_DW         = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WB_DW-1:0]     stream_s_data_i,
  input  logic                 stream_s_valid_i,
  output logic                 stream_s_ready_o,
  output logic [WB_AW-1:0]     wbm_adr_o,
  output logic [WB_DW-1:0]     wbm_dat_o,
  output logic [WB_DW/8-1:0]   wbm_sel_o,
  output logic                 wbm_we_o,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic [2:0]           wbm_cti_o,
  output logic [1:0]           wbm_bte_o,
  input  logic [WB_DW-1:0]     wbm_dat_i,
  input  logic                 wbm_ack_i,
  input  logic                 wbm_err_i,
  input  logic                 wbm_rty_i,
  input  logic [WB_AW-1:0]     wbs_adr_i,
  input  logic [WB_DW-1:0]     wbs_dat_i,
  input  logic [WB_DW/8-1:0]   wbs_sel_i,
  input  logic                 wbs_we_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic [2:0]           wbs_cti_i,
  input  logic [1:0]           wbs_bte_i,
  output logic [WB_DW-1:0]     wbs_dat_o,
  output logic                 wbs_ack_o,
  output logic                 wbs_err_o,
  output logic                 wbs_rty_o,
  output logic                 irq_o
);

  localparam int WSB = WB_DW / 8;
  localparam int ALW = $clog2(WSB);
  localparam int BCW = $clog2(MAX_BURST_LEN + 1);
  localparam logic [WB_DW-1:0] ONE_W   = WB_DW'(1);
  localparam logic [WB_DW-1:0] MAX_W   = WB_DW'(MAX_BURST_LEN);
  localparam logic [WB_DW-1:0] DEPTH_W = WB_DW'(2**FIFO_AW);

  logic               ready_en;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FIFO_AW:0]   fifo_count;
  logic [WB_DW-1:0]   fifo_count_w;
  logic [WB_DW-1:0]   fifo_head;
  logic               fifo_pop;

  logic [1:0]         state;
  logic [WB_AW-1:0]   addr;
  logic [WB_DW-1:0]   remaining;
  logic [BCW-1:0]     beats_left;
  logic [WB_DW-1:0]   len_w;

  logic               csr_busy;
  logic               csr_irq;
  logic               csr_err;
  logic [WB_AW-1:0]   start_addr;
  logic [WB_DW-1:0]   buf_size;
  logic [WB_DW-1:0]   burst_size;
  logic [WB_DW-1:0]   tx_cnt;
  logic [WB_DW-1:0]   reg_rdata;

  logic [2:0]         reg_sel;
  logic               wbs_access;
  logic               wr_access;
  logic               start_req;
  logic               start_go;
  logic               start_empty;
  logic               irq_clr;
  logic               bus_err;
  logic               xfer_done;
  logic               unused_inputs;

  assign reg_sel     = wbs_adr_i[4:2];
  assign wbs_access  = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign wr_access   = wbs_access & wbs_we_i;
  assign start_req   = wr_access && (reg_sel == REG_CSR) && wbs_dat_i[0] && !csr_busy;
  assign start_go    = start_req && (buf_size != '0);
  assign start_empty = start_req && (buf_size == '0);
  assign irq_clr     = wr_access && (reg_sel == REG_CSR) && wbs_dat_i[1];
  assign bus_err     = (state == ST_BURST) && wbm_err_i;
  assign xfer_done   = (state == ST_DONE);
  assign fifo_pop    = (state == ST_BURST) && wbm_ack_i && !wbm_err_i;
  assign fifo_count_w = WB_DW'(fifo_count);

  assign stream_s_ready_o = ready_en & ~fifo_full;

  assign wbm_cyc_o = (state == ST_BURST);
  assign wbm_stb_o = wbm_cyc_o;
  assign wbm_we_o  = wbm_cyc_o;
  assign wbm_sel_o = '1;
  assign wbm_bte_o = 2'b00;
  assign wbm_adr_o = addr;
  assign wbm_dat_o = wbm_cyc_o ? fifo_head : '0;
  assign wbm_cti_o = !wbm_cyc_o ? 3'b000 :
                     (beats_left == BCW'(1)) ? CTI_EOB : CTI_INC;

  assign wbs_err_o = 1'b0;
  assign wbs_rty_o = 1'b0;
  assign irq_o     = csr_irq;

  assign unused_inputs = ^{wbm_dat_i, wbm_rty_i, wbs_sel_i, wbs_cti_i, wbs_bte_i,
                           wbs_adr_i[WB_AW-1:5], wbs_adr_i[1:0], fifo_empty};

  stream_fifo #(.DW(WB_DW), .AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (stream_s_valid_i & ready_en),
    .wr_data (stream_s_data_i),
    .full    (fifo_full),
    .rd_en   (fifo_pop),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Stream ready stays low in reset and opens on the first clock after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // Burst length: programmed size (0 means 1), capped by the burst counter,
  // by the words still owed and by FIFO depth so a full FIFO cannot deadlock
  always_comb begin
    len_w = burst_size;
    if (len_w == '0)      len_w = ONE_W;
    if (len_w > MAX_W)    len_w = MAX_W;
    if (len_w > remaining) len_w = remaining;
    if (len_w > DEPTH_W)  len_w = DEPTH_W;
  end

  // Master FSM: wait for a full burst in the FIFO, then stream it out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      addr       <= '0;
      remaining  <= '0;
      beats_left <= '0;
      tx_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_go) begin
            addr      <= start_addr;
            remaining <= buf_size >> ALW;
            tx_cnt    <= '0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (fifo_count_w >= len_w) begin
            beats_left <= len_w[BCW-1:0];
            state      <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (wbm_err_i) begin
            state <= ST_IDLE;
          end else if (wbm_ack_i) begin
            addr       <= addr + WB_AW'(WSB);
            remaining  <= remaining - ONE_W;
            tx_cnt     <= tx_cnt + ONE_W;
            beats_left <= beats_left - BCW'(1);
            if (beats_left == BCW'(1))
              state <= (remaining == ONE_W) ? ST_DONE : ST_WAIT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Status and configuration registers; interrupt set wins over a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_busy   <= 1'b0;
      csr_irq    <= 1'b0;
      csr_err    <= 1'b0;
      start_addr <= '0;
      buf_size   <= '0;
      burst_size <= '0;
    end else begin
      if (start_go) csr_busy <= 1'b1;
      if (xfer_done || bus_err) csr_busy <= 1'b0;
      if (irq_clr) begin
        csr_irq <= 1'b0;
        csr_err <= 1'b0;
      end
      if (start_empty || xfer_done || bus_err) csr_irq <= 1'b1;
      if (bus_err) csr_err <= 1'b1;
      if (wr_access && !csr_busy) begin
        case (reg_sel)
          REG_START_ADDR: start_addr <= {wbs_dat_i[WB_AW-1:ALW], {ALW{1'b0}}};
          REG_BUF_SIZE:   buf_size   <= wbs_dat_i;
          REG_BURST_SIZE: burst_size <= wbs_dat_i;
          default: ;
        endcase
      end
    end
  end

  // Register read multiplexer; unmapped offsets read as zero
  always_comb begin
    reg_rdata = '0;
    case (reg_sel)
      REG_CSR:        reg_rdata = {{(WB_DW-3){1'b0}}, csr_err, csr_irq, csr_busy};
      REG_START_ADDR: reg_rdata = WB_DW'(start_addr);
      REG_BUF_SIZE:   reg_rdata = buf_size;
      REG_BURST_SIZE: reg_rdata = burst_size;
      REG_TX_CNT:     reg_rdata = tx_cnt;
      default:        reg_rdata = '0;
    endcase
  end

  // Slave handshake: one-cycle ack, dropped for a cycle between accesses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= wbs_access;
      if (wbs_access) wbs_dat_o <= reg_rdata;
    end
  end

endmodule

// File: tb/tb_wb_stream_reader.sv
// Self-checking bench for wb_stream_reader. Expected bus beats are queued by
// the stimulus; a memory responder pops and compares each beat it accepts.
module tb_wb_stream_reader;

  localparam logic [31:0] A_CSR   = 32'h00;
  localparam logic [31:0] A_START = 32'h04;
  localparam logic [31:0] A_BUF   = 32'h08;
  localparam logic [31:0] A_BURST = 32'h0C;
  localparam logic [31:0] A_TXCNT = 32'h10;
  localparam logic [2:0]  INC = 3'b010;
  localparam logic [2:0]  EOB = 3'b111;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [2:0]  cti;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] stream_data;
  logic        stream_valid;
  logic        stream_ready;
  logic [31:0] wbm_adr;
  logic [31:0] wbm_dat;
  logic [3:0]  wbm_sel;
  logic        wbm_we;
  logic        wbm_cyc;
  logic        wbm_stb;
  logic [2:0]  wbm_cti;
  logic [1:0]  wbm_bte;
  logic        wbm_ack;
  logic        wbm_err;
  logic [31:0] wbs_adr;
  logic [31:0] wbs_dat;
  logic        wbs_we;
  logic        wbs_cyc;
  logic        wbs_stb;
  logic [31:0] wbs_rdat;
  logic        wbs_ack;
  logic        wbs_err;
  logic        wbs_rty;
  logic        irq;

  int          n_checks = 0;
  int          n_fail = 0;
  int          beat_idx = 0;
  int          err_beat = 0;
  logic        check_drop = 1'b0;
  beat_t       exp_q[$];
  logic [31:0] words[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd;

  wb_stream_reader dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stream_s_data_i  (stream_data),
    .stream_s_valid_i (stream_valid),
    .stream_s_ready_o (stream_ready),
    .wbm_adr_o        (wbm_adr),
    .wbm_dat_o        (wbm_dat),
    .wbm_sel_o        (wbm_sel),
    .wbm_we_o         (wbm_we),
    .wbm_cyc_o        (wbm_cyc),
    .wbm_stb_o        (wbm_stb),
    .wbm_cti_o        (wbm_cti),
    .wbm_bte_o        (wbm_bte),
    .wbm_dat_i        (32'h0),
    .wbm_ack_i        (wbm_ack),
    .wbm_err_i        (wbm_err),
    .wbm_rty_i        (1'b0),
    .wbs_adr_i        (wbs_adr),
    .wbs_dat_i        (wbs_dat),
    .wbs_sel_i        (4'hF),
    .wbs_we_i         (wbs_we),
    .wbs_cyc_i        (wbs_cyc),
    .wbs_stb_i        (wbs_stb),
    .wbs_cti_i        (3'b000),
    .wbs_bte_i        (2'b00),
    .wbs_dat_o        (wbs_rdat),
    .wbs_ack_o        (wbs_ack),
    .wbs_err_o        (wbs_err),
    .wbs_rty_o        (wbs_rty),
    .irq_o            (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder and scoreboard monitor: acks every presented beat,
  // optionally answers one beat with an error instead
  initial begin
    wbm_ack = 1'b0;
    wbm_err = 1'b0;
    forever begin
      @(negedge clk);
      if (check_drop) begin
        checkOutput("err_cyc_drop", {31'b0, wbm_cyc}, 32'h0);
        check_drop = 1'b0;
      end
      wbm_ack = 1'b0;
      wbm_err = 1'b0;
      if (rst_n && wbm_cyc && wbm_stb) begin
        if (err_beat != 0 && beat_idx + 1 == err_beat) begin
          wbm_err = 1'b1;
          err_beat = 0;
          check_drop = 1'b1;
        end else begin
          wbm_ack = 1'b1;
          beat_idx++;
          mem[wbm_adr] = wbm_dat;
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_beat", wbm_adr, 32'hFFFF_FFFF);
          end else begin
            beat_t e;
            e = exp_q.pop_front();
            checkOutput("beat_adr", wbm_adr, e.adr);
            checkOutput("beat_dat", wbm_dat, e.dat);
            checkOutput("beat_cti", {29'b0, wbm_cti}, {29'b0, e.cti});
            checkOutput("beat_we_sel", {27'b0, wbm_we, wbm_sel}, 32'h1F);
          end
        end
      end
    end
  end

  task automatic wbsWrite(input logic [31:0] a, input logic [31:0] d);
    int t = 0;
    @(negedge clk);
    wbs_adr = a; wbs_dat = d; wbs_we = 1'b1; wbs_cyc = 1'b1; wbs_stb = 1'b1;
    do begin @(negedge clk); t++; end while (!wbs_ack && t < 10);
    if (!wbs_ack) checkOutput("wbs_ack_timeout", 32'h0, 32'h1);
    wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
  endtask

  task automatic wbsRead(input logic [31:0] a, output logic [31:0] d);
    int t = 0;
    @(negedge clk);
    wbs_adr = a; wbs_we = 1'b0; wbs_cyc = 1'b1; wbs_stb = 1'b1;
    do begin @(negedge clk); t++; end while (!wbs_ack && t < 10);
    if (!wbs_ack) checkOutput("wbs_ack_timeout", 32'h0, 32'h1);
    d = wbs_rdat;
    wbs_cyc = 1'b0; wbs_stb = 1'b0;
  endtask

  // Push one word into the stream port, waiting (bounded) for ready
  task automatic applyStimulus(input logic [31:0] d);
    int t = 0;
    @(negedge clk);
    stream_data = d; stream_valid = 1'b1;
    while (!stream_ready && t < 500) begin @(negedge clk); t++; end
    if (!stream_ready) checkOutput("stream_ready_timeout", 32'h0, 32'h1);
    @(posedge clk);
    #1 stream_valid = 1'b0;
  endtask

  task automatic streamRange(input int first, input int n);
    for (int i = 0; i < n; i++) applyStimulus(words[first + i]);
  endtask

  // Queue the beats a transfer of n words in bursts of b should produce
  task automatic expectBeats(input logic [31:0] base, input int first, input int n, input int b);
    beat_t e;
    for (int i = 0; i < n; i++) begin
      e.adr = base + 32'(4 * i);
      e.dat = words[first + i];
      e.cti = ((i % b) == b - 1 || i == n - 1) ? EOB : INC;
      exp_q.push_back(e);
    end
  endtask

  task automatic checkMem(input logic [31:0] base, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = base + 32'(4 * i);
      checkOutput("mem_word", mem.exists(a) ? mem[a] : 32'hDEAD_BEEF, words[first + i]);
    end
  endtask

  task automatic waitIrq(input string name, input int maxc);
    int t = 0;
    while (!irq && t < maxc) begin @(negedge clk); t++; end
    checkOutput(name, {31'b0, irq}, 32'h1);
  endtask

  task automatic makeWords(input logic [31:0] seed, input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(seed + 32'(i * 32'h0101_0011));
  endtask

  initial begin
    rst_n = 1'b0; stream_valid = 1'b0; stream_data = '0;
    wbs_adr = '0; wbs_dat = '0; wbs_we = 1'b0; wbs_cyc = 1'b0; wbs_stb = 1'b0;

    // Reset state
    #12;
    checkOutput("rst_ready", {31'b0, stream_ready}, 32'h0);
    checkOutput("rst_cyc_stb", {30'b0, wbm_cyc, wbm_stb}, 32'h0);
    checkOutput("rst_irq_ack", {30'b0, irq, wbs_ack}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("ready_after_reset", {31'b0, stream_ready}, 32'h1);
    wbsRead(A_CSR, rd); checkOutput("csr_reset", rd, 32'h0);

    // Single burst, words queued before the start
    $display("[TB] single burst");
    makeWords(32'hA000_0000, 8);
    wbsWrite(A_START, 32'h43);
    wbsWrite(A_BUF, 32);
    wbsWrite(A_BURST, 8);
    wbsRead(A_START, rd); checkOutput("start_addr_aligned", rd, 32'h40);
    streamRange(0, 8);
    expectBeats(32'h40, 0, 8, 8);
    beat_idx = 0;
    wbsWrite(A_CSR, 32'h1);
    waitIrq("irq_single", 200);
    wbsRead(A_CSR, rd); checkOutput("csr_done_single", rd, 32'h2);
    wbsRead(A_TXCNT, rd); checkOutput("txcnt_single", rd, 32'd8);
    checkMem(32'h40, 0, 8);
    checkOutput("sb_empty_single", 32'(exp_q.size()), 32'h0);
    wbsWrite(A_CSR, 32'h2);
    wbsRead(A_CSR, rd); checkOutput("csr_cleared", rd, 32'h0);

    // Short final burst: 4,4,2
    $display("[TB] short final burst");
    makeWords(32'h1234_5000, 10);
    wbsWrite(A_START, 32'h100);
    wbsWrite(A_BUF, 40);
    wbsWrite(A_BURST, 4);
    expectBeats(32'h100, 0, 10, 4);
    beat_idx = 0;
    wbsWrite(A_CSR, 32'h1);
    streamRange(0, 10);
    waitIrq("irq_short", 200);
    checkOutput("beats_short", 32'(beat_idx), 32'd10);
    wbsRead(A_TXCNT, rd); checkOutput("txcnt_short", rd, 32'd10);
    checkMem(32'h100, 0, 10);
    wbsWrite(A_CSR, 32'h2);

    // Backpressure: fill the FIFO while idle, then drain and keep streaming
    $display("[TB] backpressure");
    makeWords(32'hB000_0000, 40);
    streamRange(0, 32);
    checkOutput("ready_when_full", {31'b0, stream_ready}, 32'h0);
    wbsWrite(A_START, 32'h200);
    wbsWrite(A_BUF, 160);
    wbsWrite(A_BURST, 16);
    expectBeats(32'h200, 0, 40, 16);
    beat_idx = 0;
    wbsWrite(A_CSR, 32'h1);
    streamRange(32, 8);
    waitIrq("irq_backpressure", 400);
    wbsRead(A_TXCNT, rd); checkOutput("txcnt_backpressure", rd, 32'd40);
    checkMem(32'h200, 0, 40);
    wbsWrite(A_CSR, 32'h2);

    // Bus error on beat 3 of 8, then drain the words left in the FIFO
    $display("[TB] bus error");
    makeWords(32'hE000_0000, 8);
    wbsWrite(A_START, 32'h300);
    wbsWrite(A_BUF, 32);
    wbsWrite(A_BURST, 8);
    streamRange(0, 8);
    expectBeats(32'h300, 0, 2, 8);
    exp_q[1].cti = INC;
    beat_idx = 0;
    err_beat = 3;
    wbsWrite(A_CSR, 32'h1);
    waitIrq("irq_err", 200);
    wbsRead(A_CSR, rd); checkOutput("csr_err", rd, 32'h6);
    wbsRead(A_TXCNT, rd); checkOutput("txcnt_err", rd, 32'd2);
    wbsWrite(A_CSR, 32'h2);
    wbsRead(A_CSR, rd); checkOutput("csr_err_cleared", rd, 32'h0);
    wbsWrite(A_START, 32'h400);
    wbsWrite(A_BUF, 24);
    expectBeats(32'h400, 2, 6, 8);
    beat_idx = 0;
    wbsWrite(A_CSR, 32'h1);
    waitIrq("irq_err_drain", 200);
    checkMem(32'h400, 2, 6);
    checkOutput("sb_empty_err", 32'(exp_q.size()), 32'h0);
    wbsWrite(A_CSR, 32'h2);

    // Config lockout while busy, then start with zero buffer size
    $display("[TB] config lockout");
    makeWords(32'hC000_0000, 4);
    wbsWrite(A_START, 32'h500);
    wbsWrite(A_BUF, 16);
    wbsWrite(A_BURST, 4);
    wbsWrite(A_CSR, 32'h1);
    wbsRead(A_CSR, rd); checkOutput("csr_busy", rd, 32'h1);
    wbsWrite(A_BUF, 8);
    wbsRead(A_BUF, rd); checkOutput("buf_locked", rd, 32'd16);
    expectBeats(32'h500, 0, 4, 4);
    streamRange(0, 4);
    waitIrq("irq_lockout", 200);
    checkMem(32'h500, 0, 4);
    wbsWrite(A_CSR, 32'h2);
    wbsWrite(A_BUF, 0);
    wbsWrite(A_CSR, 32'h1);
    checkOutput("irq_zero_buf", {31'b0, irq}, 32'h1);
    repeat (6) @(negedge clk);
    wbsRead(A_CSR, rd); checkOutput("csr_zero_buf", rd, 32'h2);
    wbsWrite(A_CSR, 32'h2);

    // Asynchronous reset in the middle of a burst
    $display("[TB] reset mid-burst");
    makeWords(32'hD000_0000, 8);
    wbsWrite(A_START, 32'h600);
    wbsWrite(A_BUF, 32);
    wbsWrite(A_BURST, 8);
    streamRange(0, 8);
    expectBeats(32'h600, 0, 8, 8);
    beat_idx = 0;
    wbsWrite(A_CSR, 32'h1);
    for (int t = 0; t < 100 && beat_idx < 2; t++) @(negedge clk);
    checkOutput("reached_beat2", {31'b0, beat_idx >= 2}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_cyc_stb", {30'b0, wbm_cyc, wbm_stb}, 32'h0);
    checkOutput("async_rst_ready_irq", {30'b0, stream_ready, irq}, 32'h0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("ready_after_rst2", {31'b0, stream_ready}, 32'h1);
    wbsRead(A_CSR, rd); checkOutput("csr_after_rst2", rd, 32'h0);
    wbsRead(A_TXCNT, rd); checkOutput("txcnt_after_rst2", rd, 32'h0);
    // FIFO must be empty: a one-word transfer (burst size 0 acts as 1) waits
    makeWords(32'hC0DE_0001, 1);
    wbsWrite(A_START, 32'h700);
    wbsWrite(A_BUF, 4);
    wbsWrite(A_CSR, 32'h1);
    repeat (10) @(negedge clk);
    wbsRead(A_CSR, rd); checkOutput("fifo_empty_after_rst", rd, 32'h1);
    expectBeats(32'h700, 0, 1, 1);
    streamRange(0, 1);
    waitIrq("irq_after_rst", 100);
    checkMem(32'h700, 0, 1);
    checkOutput("sb_empty_final", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
